// File: rtl/accel_pkg.sv
// Shared types and constants for the header-match accelerator dispatch block.
package accel_pkg;
    localparam int ACTION_W  = 4;
    localparam int HDR_W     = 64;
    localparam int CMP_W     = 32;
    localparam int DEF_TID_W = 3;

    localparam logic [ACTION_W-1:0] ACTION_MATCH = 4'b1111;
    localparam logic [ACTION_W-1:0] ACTION_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;
endpackage

// File: rtl/accel_rr_arbiter.sv
// Combinational round-robin pick: first pending index at or after ptr, wrapping.
module accel_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_valid
);
    int idx;

    // Scan from the farthest offset down so the nearest pending index wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N;
            if (pending[idx]) begin
                grant     = IDX_W'(idx);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/accel_dispatch.sv
// Per-thread request slots, round-robin issue and response return for the shared accelerator.
// Define ACCEL_DISPATCH_PERF_EN to add saturating issue/match/timeout counters.
module accel_dispatch
    import accel_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int TID_W       = DEF_TID_W,
    parameter int TIMEOUT     = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_THREADS-1:0]       req_valid,
    output logic [NUM_THREADS-1:0]       req_ready,
    input  logic [NUM_THREADS*HDR_W-1:0] req_header,
    input  logic [NUM_THREADS*CMP_W-1:0] req_compare,
    output logic [NUM_THREADS-1:0]       resp_valid,
    output logic [ACTION_W-1:0]          resp_action,
    output logic                         resp_error,
    output logic                         acc_start,
    output logic [HDR_W-1:0]             acc_header,
    output logic [CMP_W-1:0]             acc_compare,
    output logic [TID_W-1:0]             acc_thread_id,
    input  logic                         acc_done,
    input  logic [ACTION_W-1:0]          acc_action,
    input  logic [TID_W-1:0]             acc_thread_id_in
`ifdef ACCEL_DISPATCH_PERF_EN
    ,
    input  logic                         perf_clear,
    output logic [31:0]                  perf_issued,
    output logic [31:0]                  perf_matched,
    output logic [15:0]                  perf_timeouts
`endif
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic [TID_W-1:0]       cur_q, cur_d;
    logic [TID_W-1:0]       rr_q, rr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACTION_W-1:0]    action_q, action_d;
    logic                   err_q, err_d;
    logic [NUM_THREADS-1:0] pending_q, pending_d;
    logic [HDR_W-1:0]       hdr_q [NUM_THREADS];
    logic [HDR_W-1:0]       hdr_d [NUM_THREADS];
    logic [CMP_W-1:0]       cmp_q [NUM_THREADS];
    logic [CMP_W-1:0]       cmp_d [NUM_THREADS];
    logic [TID_W-1:0]       grant;
    logic                   any_pending;

    accel_rr_arbiter #(
        .N     (NUM_THREADS),
        .IDX_W (TID_W)
    ) u_arb (
        .pending   (pending_q),
        .ptr       (rr_q),
        .grant     (grant),
        .any_valid (any_pending)
    );

    assign req_ready = ~pending_q;

    always_comb begin
        pending_d = pending_q;
        hdr_d     = hdr_q;
        cmp_d     = cmp_q;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (req_valid[t] && !pending_q[t]) begin
                pending_d[t] = 1'b1;
                hdr_d[t]     = req_header[t*HDR_W +: HDR_W];
                cmp_d[t]     = req_compare[t*CMP_W +: CMP_W];
            end
        end
        if (state_q == RESP) pending_d[cur_q] = 1'b0;
    end

    // IDLE pick next | ISSUE start pulse | WAIT done or timeout | RESP return to thread
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        action_d      = action_q;
        err_d         = err_q;
        acc_start     = 1'b0;
        acc_header    = '0;
        acc_compare   = '0;
        acc_thread_id = '0;
        resp_valid    = '0;
        resp_action   = '0;
        resp_error    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    cur_d   = grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                acc_start     = 1'b1;
                acc_header    = hdr_q[cur_q];
                acc_compare   = cmp_q[cur_q];
                acc_thread_id = cur_q;
                cnt_d         = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                acc_header    = hdr_q[cur_q];
                acc_compare   = cmp_q[cur_q];
                acc_thread_id = cur_q;
                if (acc_done) begin
                    action_d = acc_action;
                    err_d    = (acc_thread_id_in != cur_q);
                    state_d  = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    action_d = ACTION_NONE;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                resp_valid[cur_q] = 1'b1;
                resp_action       = action_q;
                resp_error        = err_q;
                rr_d              = (cur_q == TID_W'(NUM_THREADS - 1)) ? '0 : cur_q + TID_W'(1);
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            action_q  <= '0;
            err_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            action_q  <= action_d;
            err_q     <= err_d;
            pending_q <= pending_d;
        end
    end

    // Slot payload is only read while its pending bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
        cmp_q <= cmp_d;
    end

`ifdef ACCEL_DISPATCH_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_matched_q, perf_matched_d;
    logic [15:0] perf_timeouts_q, perf_timeouts_d;
    logic        timeout_hit;

    assign timeout_hit = (state_q == WAIT) && !acc_done && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        perf_issued_d   = perf_issued_q;
        perf_matched_d  = perf_matched_q;
        perf_timeouts_d = perf_timeouts_q;
        if (perf_clear) begin
            perf_issued_d   = '0;
            perf_matched_d  = '0;
            perf_timeouts_d = '0;
        end else begin
            if (state_q == ISSUE && perf_issued_q != '1)
                perf_issued_d = perf_issued_q + 32'd1;
            if (state_q == RESP && action_q == ACTION_MATCH && !err_q && perf_matched_q != '1)
                perf_matched_d = perf_matched_q + 32'd1;
            if (timeout_hit && perf_timeouts_q != '1)
                perf_timeouts_d = perf_timeouts_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q   <= '0;
            perf_matched_q  <= '0;
            perf_timeouts_q <= '0;
        end else begin
            perf_issued_q   <= perf_issued_d;
            perf_matched_q  <= perf_matched_d;
            perf_timeouts_q <= perf_timeouts_d;
        end
    end

    assign perf_issued   = perf_issued_q;
    assign perf_matched  = perf_matched_q;
    assign perf_timeouts = perf_timeouts_q;
`endif
endmodule

// File: tb/tb_accel_dispatch.sv
// Directed scoreboard bench for accel_dispatch with a behavioural accelerator model.
module tb_accel_dispatch;
    localparam int NT = 8;
    localparam int TO = 15;

    typedef struct {
        logic [2:0]  tid;
        logic [63:0] hdr;
        logic [31:0] cmp;
    } iss_t;

    typedef struct {
        logic [7:0] onehot;
        logic [3:0] act;
        logic       err;
    } resp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NT-1:0]   req_valid = '0;
    logic [NT-1:0]   req_ready;
    logic [NT*64-1:0] req_header = '0;
    logic [NT*32-1:0] req_compare = '0;
    logic [NT-1:0]   resp_valid;
    logic [3:0]      resp_action;
    logic            resp_error;
    logic            acc_start;
    logic [63:0]     acc_header;
    logic [31:0]     acc_compare;
    logic [2:0]      acc_thread_id;
    logic            acc_done = 1'b0;
    logic [3:0]      acc_action = '0;
    logic [2:0]      acc_thread_id_in = '0;
`ifdef ACCEL_DISPATCH_PERF_EN
    logic            perf_clear = 1'b0;
    logic [31:0]     perf_issued;
    logic [31:0]     perf_matched;
    logic [15:0]     perf_timeouts;
`endif

    int checks = 0;
    int errors = 0;
    int n_issued = 0;
    int n_matched = 0;
    iss_t  exp_iss[$];
    resp_t exp_resp[$];

    logic       acc_silent = 1'b0;
    logic       acc_bad_tid_en = 1'b0;
    logic [2:0] acc_bad_tid = '0;
    logic       force_done = 1'b0;
    logic       fire = 1'b0;
    logic [3:0] fire_act = '0;
    logic [2:0] fire_tid = '0;

    accel_dispatch #(.NUM_THREADS(NT), .TID_W(3), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_header       (req_header),
        .req_compare      (req_compare),
        .resp_valid       (resp_valid),
        .resp_action      (resp_action),
        .resp_error       (resp_error),
        .acc_start        (acc_start),
        .acc_header       (acc_header),
        .acc_compare      (acc_compare),
        .acc_thread_id    (acc_thread_id),
        .acc_done         (acc_done),
        .acc_action       (acc_action),
        .acc_thread_id_in (acc_thread_id_in)
`ifdef ACCEL_DISPATCH_PERF_EN
        ,
        .perf_clear       (perf_clear),
        .perf_issued      (perf_issued),
        .perf_matched     (perf_matched),
        .perf_timeouts    (perf_timeouts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [31:0] ip);
        return {16'h1234, ip, 16'hBEEF};
    endfunction

    task automatic req(input int t, input logic [31:0] ip, input logic [31:0] cmp);
        req_valid[t] = 1'b1;
        req_header[t*64 +: 64] = mk_hdr(ip);
        req_compare[t*32 +: 32] = cmp;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic expect_txn(input int t, input logic [31:0] ip, input logic [31:0] cmp,
                              input bit err, input bit timed_out);
        iss_t  i;
        resp_t r;
        i.tid = 3'(t);
        i.hdr = mk_hdr(ip);
        i.cmp = cmp;
        exp_iss.push_back(i);
        r.onehot = 8'(1 << t);
        r.act    = timed_out ? 4'h0 : ((ip == cmp) ? 4'hF : 4'h0);
        r.err    = err;
        exp_resp.push_back(r);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_iss.size() != 0 || exp_resp.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_iss.size() == 0 && exp_resp.size() == 0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Accelerator model: answers one cycle after start unless silenced.
    always @(negedge clk) begin : acc_model
        iss_t e;
        acc_done = force_done;
        if (fire) begin
            acc_done         = 1'b1;
            acc_action       = fire_act;
            acc_thread_id_in = fire_tid;
            fire             = 1'b0;
        end
        if (acc_start === 1'b1) begin
            n_issued++;
            if (exp_iss.size() == 0) begin
                check("iss_unexpected", 64'(acc_thread_id), 64'hFF);
            end else begin
                e = exp_iss.pop_front();
                check("iss_tid", 64'(acc_thread_id), 64'(e.tid));
                check("iss_hdr", acc_header, e.hdr);
                check("iss_cmp", 64'(acc_compare), 64'(e.cmp));
            end
            if (!acc_silent) begin
                fire     = 1'b1;
                fire_act = (acc_header[47:16] == acc_compare) ? 4'hF : 4'h0;
                fire_tid = acc_bad_tid_en ? acc_bad_tid : acc_thread_id;
            end
        end
    end

    always @(negedge clk) begin : resp_mon
        resp_t r;
        if (!reset && resp_valid !== '0) begin
            if (exp_resp.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                r = exp_resp.pop_front();
                check("resp_valid", 64'(resp_valid), 64'(r.onehot));
                check("resp_action", 64'(resp_action), 64'(r.act));
                check("resp_error", 64'(resp_error), 64'(r.err));
                if (r.act == 4'hF && !r.err) n_matched++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        int base_iss;
        int base_match;
        int n_timeouts;

        n_timeouts = 0;
        base_iss = 0;
        base_match = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'hFF);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_acc_start", 64'(acc_start), 64'd0);
        check("rst_acc_header", acc_header, 64'd0);
        check("rst_acc_tid", 64'(acc_thread_id), 64'd0);
        @(posedge clk);
        #1;

        // single matching request on thread 2, exact latency
        req(2, 32'hC0A80001, 32'hC0A80001);
        expect_txn(2, 32'hC0A80001, 32'hC0A80001, 1'b0, 1'b0);
        commit();
        @(negedge clk);
        check("t1_ready_busy", 64'(req_ready), 64'hFB);
        check("t1_n1_start", 64'(acc_start), 64'd0);
        @(negedge clk);
        check("t1_n2_start", 64'(acc_start), 64'd1);
        check("t1_n2_tid", 64'(acc_thread_id), 64'd2);
        @(negedge clk);
        check("t1_n3_start", 64'(acc_start), 64'd0);
        check("t1_n3_tid_hold", 64'(acc_thread_id), 64'd2);
        check("t1_n3_hdr_hold", acc_header, mk_hdr(32'hC0A80001));
        @(negedge clk);
        check("t1_n4_resp", 64'(resp_valid), 64'h04);
        @(negedge clk);
        check("t1_n5_ready", 64'(req_ready), 64'hFF);
        drain(40);

        // mismatch on thread 5
        req(5, 32'h0A000002, 32'h0A000001);
        expect_txn(5, 32'h0A000002, 32'h0A000001, 1'b0, 1'b0);
        commit();
        drain(40);

        // move pointer to 4 via thread 3, then 0/3/7 together -> 7, 0, 3
        req(3, 32'h11111111, 32'h11111111);
        expect_txn(3, 32'h11111111, 32'h11111111, 1'b0, 1'b0);
        commit();
        drain(40);
        req(0, 32'hA0000000, 32'hA0000000);
        req(3, 32'hA0000003, 32'h00000000);
        req(7, 32'hA0000007, 32'hA0000007);
        expect_txn(7, 32'hA0000007, 32'hA0000007, 1'b0, 1'b0);
        expect_txn(0, 32'hA0000000, 32'hA0000000, 1'b0, 1'b0);
        expect_txn(3, 32'hA0000003, 32'h00000000, 1'b0, 1'b0);
        commit();
        drain(80);

        // timeout on thread 1
        acc_silent = 1'b1;
        req(1, 32'h22222222, 32'h22222222);
        expect_txn(1, 32'h22222222, 32'h22222222, 1'b1, 1'b1);
        commit();
        cyc = 0;
        while (resp_valid !== 8'h02 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_timeout_latency", 64'(cyc), 64'(TO + 4));
        n_timeouts++;
        @(posedge clk);
        #1 force_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t4_late_resp", 64'(resp_valid), 64'd0);
            check("t4_late_start", 64'(acc_start), 64'd0);
        end
        @(posedge clk);
        #1 force_done = 1'b0;
        acc_silent = 1'b0;
        drain(40);

        // wrong returned thread id, plus a second request to the busy slot
        acc_bad_tid_en = 1'b1;
        acc_bad_tid = 3'd6;
        req(4, 32'h33333333, 32'h33333333);
        expect_txn(4, 32'h33333333, 32'h33333333, 1'b1, 1'b0);
        commit();
        req(4, 32'h44444444, 32'h44444444);
        @(negedge clk);
        check("t5_ready4_busy", 64'(req_ready[4]), 64'd0);
        commit();
        req(4, 32'h44444444, 32'h44444444);
        commit();
        drain(40);
        acc_bad_tid_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // reset while waiting
        acc_silent = 1'b1;
        req(6, 32'h55555555, 32'h55555555);
        begin
            iss_t i;
            i.tid = 3'd6;
            i.hdr = mk_hdr(32'h55555555);
            i.cmp = 32'h55555555;
            exp_iss.push_back(i);
        end
        commit();
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        base_iss = n_issued;
        base_match = n_matched;
        n_timeouts = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_ready", 64'(req_ready), 64'hFF);
        check("t6_resp_valid", 64'(resp_valid), 64'd0);
        check("t6_acc_start", 64'(acc_start), 64'd0);
        check("t6_acc_header", acc_header, 64'd0);
        check("t6_acc_compare", 64'(acc_compare), 64'd0);
        check("t6_acc_tid", 64'(acc_thread_id), 64'd0);
        check("t6_resp_err", 64'(resp_error), 64'd0);
        acc_silent = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_iss_left", 64'(exp_iss.size()), 64'd0);
        req(6, 32'h66666666, 32'h66666666);
        expect_txn(6, 32'h66666666, 32'h66666666, 1'b0, 1'b0);
        commit();
        drain(40);

`ifdef ACCEL_DISPATCH_PERF_EN
        check("perf_issued", 64'(perf_issued), 64'(n_issued - base_iss));
        check("perf_matched", 64'(perf_matched), 64'(n_matched - base_match));
        check("perf_timeouts", 64'(perf_timeouts), 64'(n_timeouts));
        perf_clear = 1'b1;
        @(posedge clk);
        #1 perf_clear = 1'b0;
        check("perf_clear", 64'(perf_issued), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/accel_dispatch.md
Name: accel_dispatch

Overview:
- Initiator side of the header-match accelerator interface.
- Accepts match requests (64-bit header plus 32-bit compare value) from up to NUM_THREADS hardware threads and keeps one pending request per thread.
- Round-robin arbitrates among pending requests, drives start/header/compare/thread_id to the accelerator, waits for action_done, and returns the 4-bit action to the requesting thread.
- Sits between the per-thread issue logic of the cores and the single shared accelerator.

Parameters:
- NUM_THREADS, 8: number of requesting threads.
- TID_W, 3: thread id width; NUM_THREADS <= 2**TID_W.
- TIMEOUT, 15: maximum WAIT cycles before aborting; at least 1; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_THREADS  per-thread request strobe
- req_ready  out  NUM_THREADS  per-thread slot empty
- req_header  in  NUM_THREADS*64  flattened headers; thread t uses bits [t*64+:64]
- req_compare  in  NUM_THREADS*32  flattened compare values; thread t uses bits [t*32+:32]
- resp_valid  out  NUM_THREADS  one-cycle response pulse, one-hot
- resp_action  out  4  action returned to the responding thread
- resp_error  out  1  timeout or thread-id mismatch on this response
- acc_start  out  1  start pulse to accelerator
- acc_header  out  64  header to accelerator
- acc_compare  out  32  compare value to accelerator
- acc_thread_id  out  TID_W  id of the issued thread
- acc_done  in  1  accelerator action_done
- acc_action  in  4  accelerator action
- acc_thread_id_in  in  TID_W  accelerator thread_id_out

Behaviour:
- Reset values: all outputs 0; req_ready all 1; state IDLE; round-robin pointer 0; all slots empty.
- Slot capture: if req_valid[t] && req_ready[t], latch header and compare into slot t and mark it pending. req_ready[t] = !pending[t] (registered).
  - The slot stays pending until its response pulse; it frees in the same cycle resp_valid[t] is high.
  - req_valid while not ready is ignored; no stall or backpressure beyond req_ready.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  - IDLE: if any slot is pending, select the first pending thread at or after the rr pointer (wrapping), register it as cur, and go to ISSUE.
  - ISSUE: one cycle with acc_start=1, acc_header/acc_compare from slot cur, acc_thread_id=cur. Go to WAIT; clear the timeout counter.
  - WAIT: acc_header/acc_compare/acc_thread_id hold; acc_start=0.
    - If acc_done: capture acc_action; set err = (acc_thread_id_in != cur); go to RESP.
    - Else if counter == TIMEOUT: action=0, err=1, go to RESP.
    - Else increment the counter.
  - RESP: resp_valid[cur]=1 for one cycle with resp_action/resp_error; pending[cur] cleared; rr pointer = cur+1 modulo NUM_THREADS; go to IDLE.
- Latency, nominal accelerator (1-cycle done): request accepted at cycle N, pending at N+1, ISSUE at N+2, done seen in WAIT at N+3, resp_valid at N+4.
- acc_done seen outside WAIT is ignored; late completions after a timeout are dropped.
- A new request to a thread whose slot just freed is accepted no earlier than the cycle after resp_valid.
- Reset mid-operation: returns to IDLE immediately, all slots are discarded, and no response is issued.
- Fairness: each pending thread is served within NUM_THREADS transactions.

Optional Feature:
- Macro ACCEL_DISPATCH_PERF_EN.
- When defined: adds outputs perf_issued (32), perf_matched (32) and perf_timeouts (16), plus input perf_clear (sync).
  - perf_issued increments on each ISSUE.
  - perf_matched increments on each RESP with action==4'b1111 and !err.
  - perf_timeouts increments on each timeout.
  - All three saturate; all clear on reset or perf_clear.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package accel_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP);
  - ACTION_W=4, HDR_W=64, CMP_W=32;
  - ACTION_MATCH=4'b1111, ACTION_NONE=4'b0000;
  - the default TID_W.
- One sub-module: accel_rr_arbiter, a combinational pending vector plus pointer to a grant index and any-valid flag. Pointer storage lives in the parent.

Test Plan:
- Single request: thread 2, header[47:16]=32'hC0A80001, compare=32'hC0A80001 -> acc_start one cycle with acc_thread_id=2; resp_valid=8'b0000_0100 four cycles after acceptance, resp_action=4'hF, resp_error=0.
- Mismatch: thread 5, compare=32'h0A000001, header IP 32'h0A000002 -> resp_valid[5] pulses with resp_action=0, resp_error=0.
- Round-robin: threads 0, 3 and 7 request in the same cycle with the pointer at 4 -> issue order 7, 0, 3; each resp_valid one-hot to the matching thread.
- Timeout: thread 1 issued, acc_done held 0 -> resp_valid[1] after TIMEOUT+1 WAIT cycles with resp_action=0, resp_error=1; a later acc_done is ignored.
- Id mismatch and backpressure:
  - acc_done returned with acc_thread_id_in=6 while cur=4 -> resp_error=1.
  - A second req_valid[4] while pending -> req_ready[4]=0 and the request is not latched.
- Reset during WAIT -> next cycle all outputs 0, req_ready all 1, no resp_valid; the block accepts new requests normally afterwards.
